hazard_stall_ctrl: RTL and testbench

//  Pipeline sequencer for the 5-stage RISC-V core. Generates PC/IF-ID write enables,
//  the NoOp_i bubble request to the main decoder, the IF/ID flush on taken beq, and a

---
 rtl/hazard_stall_ctrl_if.sv | 47 ++++
 rtl/hazard_stall_ctrl.sv | 146 ++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_stall_ctrl_if.sv
// -----------------------------------------------------------------------------
// hazard_stall_ctrl_if
//   Bundles the pipeline-side signals of the hazard/stall sequencer.
//   master : pipeline / test driver (drives hazard fields, start, mem ack)
//   slave  : hazard_stall_ctrl (drives write enables, bubble, flush, stall,
//            memory request, error flag and stall-cycle counter)
//   Signals:
//     start_i, IFID_Rs1_i/Rs2_i, IDEX_Rd_i, IDEX_MemRead_i, Branch_taken_i,
//     EXMEM_MemRead_i, EXMEM_MemWrite_i, mem_ack_i          -> to sequencer
//     PCWrite_o, IFIDWrite_o, NoOp_o, Flush_o, Stall_o, mem_req_o,
//     error_o, stall_cycles_o[CNT_W-1:0]                    <- from sequencer
// -----------------------------------------------------------------------------
interface hazard_stall_ctrl_if #(
   parameter int unsigned CNT_W = 16
);
   logic             start_i;
   logic [4:0]       IFID_Rs1_i;
   logic [4:0]       IFID_Rs2_i;
   logic [4:0]       IDEX_Rd_i;
   logic             IDEX_MemRead_i;
   logic             Branch_taken_i;
   logic             EXMEM_MemRead_i;
   logic             EXMEM_MemWrite_i;
   logic             mem_ack_i;
   logic             PCWrite_o;
   logic             IFIDWrite_o;
   logic             NoOp_o;
   logic             Flush_o;
   logic             Stall_o;
   logic             mem_req_o;
   logic             error_o;
   logic [CNT_W-1:0] stall_cycles_o;

   modport master (
      output start_i, IFID_Rs1_i, IFID_Rs2_i, IDEX_Rd_i, IDEX_MemRead_i,
             Branch_taken_i, EXMEM_MemRead_i, EXMEM_MemWrite_i, mem_ack_i,
      input  PCWrite_o, IFIDWrite_o, NoOp_o, Flush_o, Stall_o, mem_req_o,
             error_o, stall_cycles_o
   );

   modport slave (
      input  start_i, IFID_Rs1_i, IFID_Rs2_i, IDEX_Rd_i, IDEX_MemRead_i,
             Branch_taken_i, EXMEM_MemRead_i, EXMEM_MemWrite_i, mem_ack_i,
      output PCWrite_o, IFIDWrite_o, NoOp_o, Flush_o, Stall_o, mem_req_o,
             error_o, stall_cycles_o
   );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_stall_ctrl
//   Pipeline sequencer for the 5-stage RISC-V core. Produces PC / IF-ID write
//   enables, the bubble request (NoOp) to the main decoder, the IF/ID flush on
//   a taken beq, and a global freeze while data memory completes a multi-cycle
//   req/ack access. A memory access stuck longer than MEM_TIMEOUT cycles parks
//   the sequencer in a sticky error state that only reset clears.
//   Ports:
//     clk_i  : clock, rising edge
//     rst_i  : asynchronous reset, active low
//     bus    : hazard_stall_ctrl_if.slave (hazard fields in, controls out)
//   Parameters:
//     MEM_TIMEOUT : MEM_WAIT cycles without ack before ERROR
//     CNT_W       : width of the saturating stall-cycle counter
// -----------------------------------------------------------------------------
module hazard_stall_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 64,
   parameter int unsigned CNT_W       = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   hazard_stall_ctrl_if.slave    bus
);

   localparam int unsigned WCW = $clog2(MEM_TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_OFF      = 2'd0,
      S_RUN      = 2'd1,
      S_MEM_WAIT = 2'd2,
      S_ERROR    = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
   logic             done_q, done_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic mem_access;
   logic pending;
   logic load_use;
   logic count_inc;
   logic pc_write, ifid_write, noop, flush, stall, mem_req;

   assign mem_access = bus.EXMEM_MemRead_i | bus.EXMEM_MemWrite_i;
   // done_q marks the instruction currently in MEM as already served, so the
   // advancing cycle after an ack does not issue a second request for it.
   assign pending    = mem_access & ~done_q;
   assign load_use   = bus.IDEX_MemRead_i && (bus.IDEX_Rd_i != 5'd0) &&
                       ((bus.IDEX_Rd_i == bus.IFID_Rs1_i) ||
                        (bus.IDEX_Rd_i == bus.IFID_Rs2_i));

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      done_d     = done_q;
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      noop       = 1'b1;
      flush      = 1'b0;
      stall      = 1'b1;
      mem_req    = 1'b0;
      count_inc  = 1'b0;

      case (state_q)
         S_OFF: begin
            if (bus.start_i) begin
               state_d = S_RUN;
            end
         end

         S_RUN: begin
            done_d = 1'b0;
            if (pending) begin
               // Memory freeze outranks load-use and branch handling.
               mem_req    = 1'b1;
               noop       = 1'b0;
               count_inc  = 1'b1;
               state_d    = S_MEM_WAIT;
               wait_cnt_d = '0;
            end else if (load_use) begin
               // Bubble; any taken branch is ignored and re-resolved next cycle.
               stall     = 1'b0;
               count_inc = 1'b1;
            end else begin
               pc_write   = 1'b1;
               ifid_write = 1'b1;
               noop       = 1'b0;
               stall      = 1'b0;
               flush      = bus.Branch_taken_i;
            end
         end

         S_MEM_WAIT: begin
            noop       = 1'b0;
            count_inc  = 1'b1;
            wait_cnt_d = wait_cnt_q + WCW'(1);
            if (bus.mem_ack_i) begin
               state_d = S_RUN;
               done_d  = 1'b1;
            end else if (wait_cnt_q == WCW'(MEM_TIMEOUT - 1)) begin
               state_d = S_ERROR;
            end
         end

         S_ERROR: begin
            state_d = S_ERROR;
         end

         default: begin
            state_d = S_OFF;
         end
      endcase
   end

   always_comb begin
      cnt_d = cnt_q;
      if (count_inc && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q    <= S_OFF;
         wait_cnt_q <= '0;
         done_q     <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         done_q     <= done_d;
         cnt_q      <= cnt_d;
      end
   end

   assign bus.PCWrite_o      = pc_write;
   assign bus.IFIDWrite_o    = ifid_write;
   assign bus.NoOp_o         = noop;
   assign bus.Flush_o        = flush;
   assign bus.Stall_o        = stall;
   assign bus.mem_req_o      = mem_req;
   assign bus.error_o        = (state_q == S_ERROR);
   assign bus.stall_cycles_o = cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_stall_ctrl
//   Self-checking bench for hazard_stall_ctrl: directed pipeline scenarios
//   followed by randomized hazard/memory traffic, all compared against a
//   cycle-level behavioural model of the sequencer's rules.
// -----------------------------------------------------------------------------
module tb_hazard_stall_ctrl;

   localparam int unsigned MEM_TIMEOUT = 64;
   localparam int unsigned CNT_W       = 16;
   localparam logic [6:0]  OFF_FLAGS   = 7'b0010100;  // {pc,ifid,noop,flush,stall,req,err}
   localparam logic [6:0]  ERR_FLAGS   = 7'b0010101;

   logic clk_i;
   logic rst_i;

   hazard_stall_ctrl_if #(.CNT_W(CNT_W)) bus ();

   hazard_stall_ctrl #(
      .MEM_TIMEOUT (MEM_TIMEOUT),
      .CNT_W       (CNT_W)
   ) dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (bus)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   int errs   = 0;
   int checks = 0;
   int cyc    = 0;
   int req_seen;

   // Behavioural model: "running" once started, "failed" after a timeout,
   // wait_n >= 0 counts cycles spent waiting for the current access.
   bit m_started;
   bit m_failed;
   int m_wait_n;
   bit m_served;
   int m_stalls;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errs++;
         $display("FAIL %s cycle=%0d got=0x%0h expected=0x%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_started = 1'b0;
      m_failed  = 1'b0;
      m_wait_n  = -1;
      m_served  = 1'b0;
      m_stalls  = 0;
   endtask

   function automatic bit m_load_use();
      return bus.IDEX_MemRead_i && (bus.IDEX_Rd_i != 0) &&
             (bus.IDEX_Rd_i == bus.IFID_Rs1_i || bus.IDEX_Rd_i == bus.IFID_Rs2_i);
   endfunction

   function automatic bit m_pending();
      return (bus.EXMEM_MemRead_i || bus.EXMEM_MemWrite_i) && !m_served;
   endfunction

   function automatic logic [6:0] exp_flags();
      if (!m_started)    return OFF_FLAGS;
      if (m_failed)      return ERR_FLAGS;
      if (m_wait_n >= 0) return 7'b0000100;
      if (m_pending())   return 7'b0000110;
      if (m_load_use())  return 7'b0010000;
      return {2'b11, 1'b0, bus.Branch_taken_i, 3'b000};
   endfunction

   function automatic logic [6:0] obs_flags();
      return {bus.PCWrite_o, bus.IFIDWrite_o, bus.NoOp_o, bus.Flush_o,
              bus.Stall_o, bus.mem_req_o, bus.error_o};
   endfunction

   task automatic add_stall();
      if (m_stalls < (2 ** CNT_W) - 1) m_stalls++;
   endtask

   task automatic model_step();
      if (!m_started) begin
         if (bus.start_i) m_started = 1'b1;
      end else if (m_failed) begin
         // sticky until reset
      end else if (m_wait_n >= 0) begin
         add_stall();
         if (bus.mem_ack_i) begin
            m_wait_n = -1;
            m_served = 1'b1;
         end else if (m_wait_n == MEM_TIMEOUT - 1) begin
            m_failed = 1'b1;
         end else begin
            m_wait_n++;
         end
      end else begin
         if (m_pending()) begin
            m_wait_n = 0;
            add_stall();
         end else if (m_load_use()) begin
            add_stall();
         end
         m_served = 1'b0;
      end
   endtask

   task automatic drive(input bit start, input int rs1, input int rs2, input int rd,
                        input bit idex_mr, input bit br, input bit mr, input bit mw,
                        input bit ack);
      bus.start_i          = start;
      bus.IFID_Rs1_i       = 5'(rs1);
      bus.IFID_Rs2_i       = 5'(rs2);
      bus.IDEX_Rd_i        = 5'(rd);
      bus.IDEX_MemRead_i   = idex_mr;
      bus.Branch_taken_i   = br;
      bus.EXMEM_MemRead_i  = mr;
      bus.EXMEM_MemWrite_i = mw;
      bus.mem_ack_i        = ack;
   endtask

   task automatic tick();
      @(negedge clk_i);
      check_eq("flags", 32'(obs_flags()), 32'(exp_flags()));
      check_eq("count", 32'(bus.stall_cycles_o), 32'(m_stalls));
      if (bus.mem_req_o) req_seen++;
      model_step();
      cyc++;
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      rst_i = 1'b0;
      model_reset();
      #1;
      check_eq("reset_flags", 32'(obs_flags()), 32'(OFF_FLAGS));
      check_eq("reset_count", 32'(bus.stall_cycles_o), 32'd0);
      @(posedge clk_i);
      #1;
      rst_i = 1'b1;
   endtask

   initial begin
      rst_i = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      model_reset();
      repeat (2) @(posedge clk_i);
      #1;
      do_reset();

      // Idle in OFF for 5 cycles, then start.
      repeat (5) tick();
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0); tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

      // Load-use on x5, then rd = x0 must not stall.
      drive(0, 5, 1, 5, 1, 0, 0, 0, 0); tick();
      drive(0, 0, 0, 0, 1, 0, 0, 0, 0); tick();

      // Taken beq hidden by load-use, resolved the following cycle.
      drive(0, 2, 7, 7, 1, 1, 0, 0, 0); tick();
      drive(0, 2, 7, 7, 0, 1, 0, 0, 0); tick();

      // sw in MEM, ack three cycles after the request.
      req_seen = 0;
      drive(0, 0, 0, 0, 0, 0, 0, 1, 0); tick();
      tick();
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 1, 1); tick();
      drive(0, 0, 0, 0, 0, 0, 0, 1, 0); tick();
      check_eq("sw_req_pulses", 32'(req_seen), 32'd1);
      check_eq("sw_stall_count", 32'(bus.stall_cycles_o), 32'd6);

      // Two consecutive lw, one-cycle ack each.
      req_seen = 0;
      drive(0, 0, 0, 0, 0, 0, 1, 0, 0); tick();
      drive(0, 0, 0, 0, 0, 0, 1, 0, 1); tick();
      drive(0, 0, 0, 0, 0, 0, 1, 0, 0); tick();
      tick();
      drive(0, 0, 0, 0, 0, 0, 1, 0, 1); tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
      check_eq("lw_req_pulses", 32'(req_seen), 32'd2);
      check_eq("lw_stall_count", 32'(bus.stall_cycles_o), 32'd10);

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 1) == 1,
               int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               int'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
               $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
               $urandom_range(0, 3) == 0, $urandom_range(0, 9) < 3);
         tick();
      end

      // Timeout: no ack for MEM_TIMEOUT wait cycles.
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      do_reset();
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0); tick();
      drive(0, 0, 0, 0, 0, 0, 1, 0, 0); tick();
      repeat (MEM_TIMEOUT) tick();
      drive(1, 0, 0, 0, 0, 1, 1, 0, 1);
      repeat (3) tick();
      check_eq("error_sticky", 32'(bus.error_o), 32'd1);

      // Reset in the middle of a memory wait.
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      do_reset();
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0); tick();
      drive(0, 0, 0, 0, 0, 0, 0, 1, 0); tick();
      repeat (5) tick();
      check_eq("pre_reset_stall", 32'(bus.Stall_o), 32'd1);
      do_reset();
      repeat (2) tick();

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
